// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings plus the responder's FSM state types.
// Reused by the DMA benches, so keep the burst/resp constants stable.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Only full-width INCR bursts are legal; anything else still moves data as INCR.
  function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size,
                                   input logic [2:0] full_size);
    return (burst != BURST_INCR) || (size != full_size);
  endfunction

endpackage

// File: rtl/axi4_mem_responder_if.sv
// AXI4 memory port between a DMA master and the BRAM-backed responder.
// Every channel: a transfer happens on the clock edge where valid && ready are both high;
// the source holds valid and its payload steady until that edge, ready may change freely.
interface axi4_mem_responder_if #(
  parameter int ID_BITS   = 6,
  parameter int ADDR_BITS = 49,
  parameter int DATA_BITS = 128
);
  logic [ID_BITS-1:0]     awid;
  logic [ADDR_BITS-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;

  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [ID_BITS-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  logic [ID_BITS-1:0]     arid;
  logic [ADDR_BITS-1:0]   araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;

  logic [ID_BITS-1:0]     rid;
  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_mem_responder_ram.sv
// Simple dual-port RAM: port A writes with byte enables, port B reads synchronously.
// A same-cycle read of the word being written returns the old contents.
module axi4_mem_responder_ram #(
  parameter int    DATA_BITS = 128,
  parameter int    ADDR_BITS = 12,
  parameter string RAM_TYPE  = "block"
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic [DATA_BITS/8-1:0] wstrb,
  input  logic                   re,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [DATA_BITS-1:0]   rdata
);

  if (RAM_TYPE != "block" && RAM_TYPE != "distributed" && RAM_TYPE != "ultra" &&
      RAM_TYPE != "registers" && RAM_TYPE != "auto") begin : g_bad_ram_type
    $error("axi4_mem_responder_ram: unsupported RAM_TYPE");
  end

  (* ram_style = RAM_TYPE *) logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_BITS / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by on-chip RAM: one write and one read burst in flight, independent paths.
// Reads stream through a 2-entry skid buffer so rready back-pressure never drops a beat.
module axi4_mem_responder
  import axi4_pkg::*;
#(
  parameter int    ID_BITS       = 6,
  parameter int    ADDR_BITS     = 49,
  parameter int    DATA_BITS     = 128,
  parameter int    MEM_ADDR_BITS = 12,
  parameter string RAM_TYPE      = "block"
) (
  input  logic                s_axi4_aclk,
  input  logic                s_axi4_aresetn,
  axi4_mem_responder_if.slave s_axi4,
  output w_state_t            w_state,
  output r_state_t            r_state
);

  localparam int         LSB       = $clog2(DATA_BITS / 8);
  localparam logic [2:0] FULL_SIZE = 3'(LSB);

  logic                     clk;
  logic                     rst_n;
  assign clk   = s_axi4_aclk;
  assign rst_n = s_axi4_aresetn;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi4.awaddr[ADDR_BITS-1:LSB+MEM_ADDR_BITS], s_axi4.awaddr[LSB-1:0],
                              s_axi4.araddr[ADDR_BITS-1:LSB+MEM_ADDR_BITS], s_axi4.araddr[LSB-1:0]};

  // Write path
  logic [ID_BITS-1:0]       w_id;
  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic [7:0]               w_len;
  logic [7:0]               w_cnt;
  logic                     w_err;
  logic                     ram_we;

  assign ram_we = (w_state == W_DATA) && s_axi4.wvalid && s_axi4.wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state        <= W_IDLE;
      s_axi4.awready <= 1'b1;
      s_axi4.wready  <= 1'b0;
      s_axi4.bvalid  <= 1'b0;
      s_axi4.bid     <= '0;
      s_axi4.bresp   <= RESP_OKAY;
      w_id           <= '0;
      w_idx          <= '0;
      w_len          <= '0;
      w_cnt          <= '0;
      w_err          <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi4.awvalid && s_axi4.awready) begin
          w_id           <= s_axi4.awid;
          w_idx          <= s_axi4.awaddr[LSB +: MEM_ADDR_BITS];
          w_len          <= s_axi4.awlen;
          w_cnt          <= '0;
          w_err          <= req_err(s_axi4.awburst, s_axi4.awsize, FULL_SIZE);
          s_axi4.awready <= 1'b0;
          s_axi4.wready  <= 1'b1;
          w_state        <= W_DATA;
        end
        W_DATA: if (s_axi4.wvalid && s_axi4.wready) begin
          w_idx <= w_idx + MEM_ADDR_BITS'(1);
          w_cnt <= w_cnt + 8'd1;
          // awlen alone decides the burst end; a wlast that disagrees only flags the response.
          if (w_cnt == w_len) begin
            s_axi4.wready <= 1'b0;
            s_axi4.bvalid <= 1'b1;
            s_axi4.bid    <= w_id;
            s_axi4.bresp  <= (w_err || !s_axi4.wlast) ? RESP_SLVERR : RESP_OKAY;
            w_state       <= W_RESP;
          end else if (s_axi4.wlast) begin
            w_err <= 1'b1;
          end
        end
        W_RESP: if (s_axi4.bready) begin
          s_axi4.bvalid  <= 1'b0;
          s_axi4.awready <= 1'b1;
          w_state        <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path
  logic [ID_BITS-1:0]       r_id;
  logic [1:0]               r_resp;
  logic [MEM_ADDR_BITS-1:0] r_idx;
  logic [8:0]               r_issue_left;
  logic                     infl;
  logic                     infl_last;
  logic [1:0]               occ;
  logic [1:0]               occ_after_pop;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [DATA_BITS-1:0]     buf_data [2];
  logic                     buf_last [2];
  logic                     pop;
  logic                     rd_en;
  logic [DATA_BITS-1:0]     ram_dout;

  assign s_axi4.rvalid = (occ != 2'd0);
  assign s_axi4.rdata  = buf_data[rd_ptr];
  assign s_axi4.rlast  = s_axi4.rvalid && buf_last[rd_ptr];
  assign s_axi4.rid    = r_id;
  assign s_axi4.rresp  = r_resp;

  assign pop           = s_axi4.rvalid && s_axi4.rready;
  // Counting the beat leaving this cycle is what lets one read issue per cycle at rready=1.
  assign occ_after_pop = occ - 2'(pop);
  assign rd_en         = (r_state == R_DATA) && (r_issue_left != 9'd0) &&
                         ((occ_after_pop + 2'(infl)) < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= R_IDLE;
      s_axi4.arready <= 1'b1;
      r_id           <= '0;
      r_resp         <= RESP_OKAY;
      r_idx          <= '0;
      r_issue_left   <= '0;
      infl           <= 1'b0;
      infl_last      <= 1'b0;
      occ            <= 2'd0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      buf_last[0]    <= 1'b0;
      buf_last[1]    <= 1'b0;
    end else begin
      if (infl) begin
        buf_last[wr_ptr] <= infl_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ       <= occ + 2'(infl) - 2'(pop);
      infl      <= rd_en;
      infl_last <= rd_en && (r_issue_left == 9'd1);
      if (rd_en) begin
        r_idx        <= r_idx + MEM_ADDR_BITS'(1);
        r_issue_left <= r_issue_left - 9'd1;
      end
      case (r_state)
        R_IDLE: if (s_axi4.arvalid && s_axi4.arready) begin
          r_id           <= s_axi4.arid;
          r_resp         <= req_err(s_axi4.arburst, s_axi4.arsize, FULL_SIZE) ? RESP_SLVERR : RESP_OKAY;
          r_idx          <= s_axi4.araddr[LSB +: MEM_ADDR_BITS];
          r_issue_left   <= {1'b0, s_axi4.arlen} + 9'd1;
          s_axi4.arready <= 1'b0;
          r_state        <= R_DATA;
        end
        R_DATA: if (pop && s_axi4.rlast) begin
          s_axi4.arready <= 1'b1;
          r_state        <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (infl) buf_data[wr_ptr] <= ram_dout;
  end

  axi4_mem_responder_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (MEM_ADDR_BITS),
    .RAM_TYPE  (RAM_TYPE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_idx),
    .wdata (s_axi4.wdata),
    .wstrb (s_axi4.wstrb),
    .re    (rd_en),
    .raddr (r_idx),
    .rdata (ram_dout)
  );

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: drivers push expected B/R responses into queues,
// negedge monitors pop and compare whenever the DUT completes a handshake.
module tb_axi4_mem_responder;
  import axi4_pkg::*;

  logic clk;
  logic rst_n;
  w_state_t w_state;
  r_state_t r_state;

  axi4_mem_responder_if #(.ID_BITS(6), .ADDR_BITS(49), .DATA_BITS(128)) s_axi4 ();

  axi4_mem_responder #(
    .ID_BITS(6), .ADDR_BITS(49), .DATA_BITS(128), .MEM_ADDR_BITS(12), .RAM_TYPE("block")
  ) dut (
    .s_axi4_aclk    (clk),
    .s_axi4_aresetn (rst_n),
    .s_axi4         (s_axi4),
    .w_state        (w_state),
    .r_state        (r_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  logic [7:0]   b_exp_q[$];
  logic [136:0] r_exp_q[$];
  logic [127:0] wdat [0:255];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_r(input int id, input logic [127:0] d, input logic [1:0] resp, input logic last);
    r_exp_q.push_back({6'(id), resp, last, d});
  endtask

  // scoreboard monitors
  logic [136:0] stall_val;
  logic         stall_seen = 1'b0;

  always @(negedge clk) begin
    logic [136:0] got;
    logic [7:0]   bgot;
    if (rst_n) begin
      got = {s_axi4.rid, s_axi4.rresp, s_axi4.rlast, s_axi4.rdata};
      if (stall_seen && s_axi4.rvalid) chk("r_stable", 160'(got), 160'(stall_val));
      if (s_axi4.rvalid && s_axi4.rready) begin
        if (r_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_unexpected: got %h expected no beat", got);
        end else begin
          chk("r_beat", 160'(got), 160'(r_exp_q.pop_front()));
        end
      end
      stall_seen = s_axi4.rvalid && !s_axi4.rready;
      stall_val  = got;
      if (s_axi4.bvalid && s_axi4.bready) begin
        bgot = {s_axi4.bid, s_axi4.bresp};
        if (b_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected: got %h expected no response", bgot);
        end else begin
          chk("b_resp", 160'(bgot), 160'(b_exp_q.pop_front()));
        end
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  // drivers
  // last_mode: 0 wlast on final beat, 1 wlast never, 2 wlast on first beat only
  task automatic wr_burst(input int id, input logic [48:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [15:0] strb, input int last_mode,
                          input int abort_at, input logic [1:0] resp);
    int n;
    if (abort_at < 0) b_exp_q.push_back({6'(id), resp});
    s_axi4.awid = 6'(id); s_axi4.awaddr = addr; s_axi4.awlen = 8'(len);
    s_axi4.awburst = burst; s_axi4.awsize = size; s_axi4.awvalid = 1'b1;
    n = 0;
    while (!s_axi4.awready && n < 100) begin tick; n++; end
    chk("aw_wait", 160'(n >= 100), 160'(0));
    tick;
    s_axi4.awvalid = 1'b0;
    chk("aw_to_wready", 160'(s_axi4.wready), 160'(1));
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        s_axi4.wvalid = 1'b0;
        return;
      end
      s_axi4.wdata = wdat[i];
      s_axi4.wstrb = strb;
      s_axi4.wlast = (last_mode == 0) ? (i == len) : (last_mode == 2) ? (i == 0) : 1'b0;
      s_axi4.wvalid = 1'b1;
      n = 0;
      while (!s_axi4.wready && n < 100) begin tick; n++; end
      if (n >= 100) chk("w_wait", 160'(n), 160'(0));
      tick;
    end
    s_axi4.wvalid = 1'b0;
    s_axi4.wlast  = 1'b0;
    chk("w_to_bvalid", 160'(s_axi4.bvalid), 160'(1));
  endtask

  task automatic rd_burst(input int id, input logic [48:0] addr, input int len, input logic [2:0] size,
                          input bit check_lat);
    int n;
    s_axi4.arid = 6'(id); s_axi4.araddr = addr; s_axi4.arlen = 8'(len);
    s_axi4.arburst = BURST_INCR; s_axi4.arsize = size; s_axi4.arvalid = 1'b1;
    n = 0;
    while (!s_axi4.arready && n < 100) begin tick; n++; end
    chk("ar_wait", 160'(n >= 100), 160'(0));
    tick;
    s_axi4.arvalid = 1'b0;
    if (check_lat) begin
      chk("ar_lat0", 160'(s_axi4.rvalid), 160'(0));
      tick;
      chk("ar_lat1", 160'(s_axi4.rvalid), 160'(0));
      tick;
      chk("ar_lat2", 160'(s_axi4.rvalid), 160'(1));
    end
  endtask

  task automatic drain;
    int n = 0;
    while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 2000) begin tick; n++; end
    chk("drain_timeout", 160'(n >= 2000), 160'(0));
    tick;
  endtask

  function automatic logic [127:0] pat1(input int i);
    return {96'h0123456789ABCDEFFEDCBA98, 32'(i + 1)};
  endfunction

  function automatic logic [127:0] pat4(input int i);
    return {32'hDEADBEEF, 64'(i * 3), 32'(i)};
  endfunction

  initial begin
    logic [7:0] rpat;
    int cyc;
    s_axi4.awid = '0; s_axi4.awaddr = '0; s_axi4.awlen = '0; s_axi4.awsize = 3'd4;
    s_axi4.awburst = BURST_INCR; s_axi4.awvalid = 1'b0;
    s_axi4.wdata = '0; s_axi4.wstrb = '0; s_axi4.wlast = 1'b0; s_axi4.wvalid = 1'b0;
    s_axi4.bready = 1'b1;
    s_axi4.arid = '0; s_axi4.araddr = '0; s_axi4.arlen = '0; s_axi4.arsize = 3'd4;
    s_axi4.arburst = BURST_INCR; s_axi4.arvalid = 1'b0; s_axi4.rready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;

    // reset state: awready, arready, wready, bvalid, rvalid, rlast, bid, rid, bresp, rresp
    chk("reset_outputs",
        160'({s_axi4.awready, s_axi4.arready, s_axi4.wready, s_axi4.bvalid, s_axi4.rvalid,
              s_axi4.rlast, s_axi4.bid, s_axi4.rid, s_axi4.bresp, s_axi4.rresp}),
        160'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 2'd0, 2'd0}));
    chk("reset_states", 160'({w_state, r_state}), 160'({W_IDLE, R_IDLE}));
    tick;

    // 1: four-beat INCR write to word 0x10
    for (int i = 0; i < 4; i++) wdat[i] = pat1(i);
    wr_burst(5, 49'h100, 3, BURST_INCR, 3'd4, 16'hFFFF, 0, -1, RESP_OKAY);
    drain;

    // 2: read it back at full rate
    for (int i = 0; i < 4; i++) exp_r(9, pat1(i), RESP_OKAY, i == 3);
    rd_burst(9, 49'h100, 3, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("r_back_to_back", 160'(s_axi4.rvalid), 160'(1));
    end
    drain;
    chk("r_idle_after_burst", 160'({r_state, s_axi4.arready}), 160'({R_IDLE, 1'b1}));

    // 3: byte enables on a preloaded word
    wdat[0] = {128{1'b1}};
    wr_burst(2, 49'h100, 0, BURST_INCR, 3'd4, 16'hFFFF, 0, -1, RESP_OKAY);
    wdat[0] = {16{8'h5A}};
    wr_burst(2, 49'h100, 0, BURST_INCR, 3'd4, 16'h000F, 0, -1, RESP_OKAY);
    drain;
    exp_r(4, {96'hFFFFFFFFFFFFFFFFFFFFFFFF, 32'h5A5A5A5A}, RESP_OKAY, 1'b1);
    rd_burst(4, 49'h100, 0, 3'd4, 1'b0);
    drain;

    // 4: 16-beat read under rready back-pressure
    for (int i = 0; i < 16; i++) wdat[i] = pat4(i);
    wr_burst(3, 49'h400, 15, BURST_INCR, 3'd4, 16'hFFFF, 0, -1, RESP_OKAY);
    drain;
    for (int i = 0; i < 16; i++) exp_r(3, pat4(i), RESP_OKAY, i == 15);
    rpat = 8'b1001_1010;
    s_axi4.rready = 1'b0;
    rd_burst(3, 49'h400, 15, 3'd4, 1'b0);
    cyc = 0;
    while (r_exp_q.size() != 0 && cyc < 500) begin
      s_axi4.rready = rpat[cyc % 8];
      tick;
      cyc++;
    end
    s_axi4.rready = 1'b1;
    drain;

    // 5: wrap at the RAM end, ignored upper address bits, error responses
    wdat[0] = {4{32'hCAFE0000}};
    wdat[1] = {4{32'hCAFE0001}};
    wr_burst(1, 49'hFFF0, 1, BURST_INCR, 3'd4, 16'hFFFF, 0, -1, RESP_OKAY);
    drain;
    exp_r(1, {4{32'hCAFE0000}}, RESP_OKAY, 1'b0);
    exp_r(1, {4{32'hCAFE0001}}, RESP_OKAY, 1'b1);
    rd_burst(1, 49'hFFF0, 1, 3'd4, 1'b0);
    drain;
    exp_r(6, {4{32'hCAFE0001}}, RESP_OKAY, 1'b1);
    rd_burst(6, 49'h0, 0, 3'd4, 1'b0);
    drain;
    exp_r(7, {4{32'hCAFE0000}}, RESP_OKAY, 1'b1);
    rd_burst(7, 49'h1_0000_0000_FFF8, 0, 3'd4, 1'b0);
    drain;

    wdat[0] = {4{32'hB0B00000}};
    wdat[1] = {4{32'hB0B00001}};
    wr_burst(10, 49'h200, 1, BURST_WRAP, 3'd4, 16'hFFFF, 0, -1, RESP_SLVERR);
    drain;
    exp_r(11, {4{32'hB0B00000}}, RESP_OKAY, 1'b0);
    exp_r(11, {4{32'hB0B00001}}, RESP_OKAY, 1'b1);
    rd_burst(11, 49'h200, 1, 3'd4, 1'b0);
    drain;
    exp_r(12, {4{32'hB0B00000}}, RESP_SLVERR, 1'b1);
    rd_burst(12, 49'h200, 0, 3'd3, 1'b0);
    drain;
    wr_burst(13, 49'h300, 0, BURST_INCR, 3'd3, 16'hFFFF, 0, -1, RESP_SLVERR);
    wr_burst(14, 49'h500, 1, BURST_INCR, 3'd4, 16'hFFFF, 1, -1, RESP_SLVERR);
    wdat[0] = 128'h600; wdat[1] = 128'h601; wdat[2] = 128'h602;
    wr_burst(15, 49'h600, 2, BURST_INCR, 3'd4, 16'hFFFF, 2, -1, RESP_SLVERR);
    drain;
    exp_r(16, 128'h600, RESP_OKAY, 1'b0);
    exp_r(16, 128'h601, RESP_OKAY, 1'b0);
    exp_r(16, 128'h602, RESP_OKAY, 1'b1);
    rd_burst(16, 49'h600, 2, 3'd4, 1'b0);
    drain;

    // 6: reset in the middle of an 8-beat write, then recover
    for (int i = 0; i < 8; i++) wdat[i] = 128'(32'h8000 + i);
    wr_burst(20, 49'h800, 7, BURST_INCR, 3'd4, 16'hFFFF, 0, 2, RESP_OKAY);
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("abort_outputs",
        160'({s_axi4.awready, s_axi4.wready, s_axi4.bvalid, s_axi4.arready, s_axi4.rvalid}),
        160'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
    chk("abort_states", 160'({w_state, r_state}), 160'({W_IDLE, R_IDLE}));

    s_axi4.bready = 1'b0;
    wdat[0] = 128'h7700; wdat[1] = 128'h7701;
    wr_burst(21, 49'h800, 1, BURST_INCR, 3'd4, 16'hFFFF, 0, -1, RESP_OKAY);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("bvalid_held", 160'({s_axi4.bvalid, s_axi4.bid}), 160'({1'b1, 6'd21}));
    end
    s_axi4.bready = 1'b1;
    drain;
    exp_r(22, 128'h7700, RESP_OKAY, 1'b0);
    exp_r(22, 128'h7701, RESP_OKAY, 1'b1);
    rd_burst(22, 49'h800, 1, 3'd4, 1'b1);
    drain;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
